// File: rtl/cfu_if_pkg.sv
// Shared types and helpers for the CFU command/response initiator.
// Bundle widths, FSM states and the no-response opcode test.
package cfu_if_pkg;

  localparam int FUNCT_W = 10;
  localparam int DATA_W  = 32;
  localparam int CMD_W   = FUNCT_W + 2 * DATA_W;
  localparam int RSP_W   = DATA_W + FUNCT_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_e;

  function automatic logic is_nop(input logic [FUNCT_W-1:0] f);
    return (f & FUNCT_W'(7)) == '0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count.
// A push on a full FIFO is honoured when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             full, do_push, do_pop;

  assign full    = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cfu_cmd_initiator.sv
// CPU-side CFU initiator: queues host commands, issues one at a time,
// and collects responses (or timeouts) into a response FIFO.
module cfu_cmd_initiator
  import cfu_if_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_in_valid,
  output logic        cmd_in_ready,
  input  logic [9:0]  cmd_in_funct,
  input  logic [31:0] cmd_in_op0,
  input  logic [31:0] cmd_in_op1,
  output logic        rsp_out_valid,
  input  logic        rsp_out_ready,
  output logic [31:0] rsp_out_data,
  output logic [9:0]  rsp_out_funct,
  output logic        rsp_out_timeout,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        busy,
  output logic [7:0]  timeout_cnt
);

  localparam int CCW = $clog2(CMD_DEPTH) + 1;
  localparam int RCW = $clog2(RSP_DEPTH) + 1;
  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  logic [CMD_W-1:0]   cmd_wdata, cmd_rdata;
  logic               cmd_push, cmd_pop, cmd_empty, cmd_full;
  logic [CCW-1:0]     cmd_cnt;
  logic [RSP_W-1:0]   rsp_wdata, rsp_rdata;
  logic               rsp_push, rsp_pop, rsp_empty, rsp_full;
  logic [RCW-1:0]     rsp_cnt;

  state_e             state_q, state_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic [7:0]         wcnt_q, wcnt_d;
  logic [7:0]         tcnt_q, tcnt_d;

  logic [FUNCT_W-1:0] head_funct;
  logic [DATA_W-1:0]  head_op0, head_op1;
  logic               issuing, hs;

  assign head_funct = cmd_rdata[CMD_W-1 -: FUNCT_W];
  assign head_op0   = cmd_rdata[2*DATA_W-1 -: DATA_W];
  assign head_op1   = cmd_rdata[DATA_W-1:0];

  assign cmd_full     = cmd_cnt == CCW'(CMD_DEPTH);
  assign rsp_full     = rsp_cnt == RCW'(RSP_DEPTH);
  assign cmd_in_ready = !cmd_full;
  assign cmd_push     = cmd_in_valid && cmd_in_ready;
  assign cmd_wdata    = {cmd_in_funct, cmd_in_op0, cmd_in_op1};

  sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (cmd_push),
    .pop_i   (cmd_pop),
    .wdata_i (cmd_wdata),
    .rdata_o (cmd_rdata),
    .empty_o (cmd_empty),
    .count_o (cmd_cnt)
  );

  sync_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rsp_push),
    .pop_i   (rsp_pop),
    .wdata_i (rsp_wdata),
    .rdata_o (rsp_rdata),
    .empty_o (rsp_empty),
    .count_o (rsp_cnt)
  );

  assign issuing = state_q == ISSUE;
  assign cmd_payload_function_id = issuing ? head_funct : '0;
  assign cmd_payload_inputs_0    = issuing ? head_op0   : '0;
  assign cmd_payload_inputs_1    = issuing ? head_op1   : '0;

  assign rsp_out_valid   = !rsp_empty;
  assign rsp_pop         = rsp_out_valid && rsp_out_ready;
  assign rsp_out_data    = rsp_empty ? '0 : rsp_rdata[RSP_W-1 -: DATA_W];
  assign rsp_out_funct   = rsp_empty ? '0 : rsp_rdata[FUNCT_W:1];
  assign rsp_out_timeout = !rsp_empty && rsp_rdata[0];

  assign busy        = (state_q != IDLE) || !cmd_empty;
  assign timeout_cnt = tcnt_q;

  always_comb begin
    state_d   = state_q;
    funct_d   = funct_q;
    wcnt_d    = wcnt_q;
    tcnt_d    = tcnt_q;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    cmd_pop   = 1'b0;
    rsp_push  = 1'b0;
    rsp_wdata = '0;
    hs        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cmd_empty) state_d = ISSUE;
      end
      ISSUE: begin
        rsp_ready = !rsp_full;
        cmd_valid = !rsp_full;
        hs        = !rsp_full && cmd_ready;
        if (hs) begin
          cmd_pop = 1'b1;
          if (is_nop(head_funct) || rsp_valid) begin
            rsp_push  = !is_nop(head_funct);
            rsp_wdata = {rsp_payload_outputs_0, head_funct, 1'b0};
            state_d   = (cmd_cnt > CCW'(1)) ? ISSUE : IDLE;
          end else begin
            funct_d = head_funct;
            wcnt_d  = '0;
            state_d = WAIT_RSP;
          end
        end
      end
      WAIT_RSP: begin
        rsp_ready = !rsp_full;
        if (rsp_valid && !rsp_full) begin
          rsp_push  = 1'b1;
          rsp_wdata = {rsp_payload_outputs_0, funct_q, 1'b0};
          state_d   = cmd_empty ? IDLE : ISSUE;
        end else if (wcnt_q == TO8) begin
          // hold here until the timeout record has room
          if (!rsp_full) begin
            rsp_push  = 1'b1;
            rsp_wdata = {{DATA_W{1'b0}}, funct_q, 1'b1};
            tcnt_d    = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
            state_d   = cmd_empty ? IDLE : ISSUE;
          end
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      funct_q <= '0;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      funct_q <= funct_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
    end
  end

endmodule

// File: tb/tb_cfu_cmd_initiator.sv
// Scoreboard bench for cfu_cmd_initiator with a behavioural Cfu model.
// Expected responses are queued at stimulus time and checked by a monitor.
module tb_cfu_cmd_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_in_valid = 1'b0;
  logic        cmd_in_ready;
  logic [9:0]  cmd_in_funct = '0;
  logic [31:0] cmd_in_op0 = '0;
  logic [31:0] cmd_in_op1 = '0;
  logic        rsp_out_valid;
  logic        rsp_out_ready = 1'b1;
  logic [31:0] rsp_out_data;
  logic [9:0]  rsp_out_funct;
  logic        rsp_out_timeout;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        busy;
  logic [7:0]  timeout_cnt;

  typedef struct packed {
    logic [31:0] d;
    logic [9:0]  f;
    logic        t;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   hs_cnt = 0;
  int   run = 0;
  int   last_run = 0;
  int   base;
  logic mode_imm = 1'b1;
  logic stray = 1'b0;
  logic [31:0] full_exp [6] = '{32'h10, 32'h20, 32'h30,
                                 32'h40, 32'h50, 32'h60};

  cfu_cmd_initiator #(
    .CMD_DEPTH(4),
    .RSP_DEPTH(4),
    .TIMEOUT(255)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cmd_in_valid            (cmd_in_valid),
    .cmd_in_ready            (cmd_in_ready),
    .cmd_in_funct            (cmd_in_funct),
    .cmd_in_op0              (cmd_in_op0),
    .cmd_in_op1              (cmd_in_op1),
    .rsp_out_valid           (rsp_out_valid),
    .rsp_out_ready           (rsp_out_ready),
    .rsp_out_data            (rsp_out_data),
    .rsp_out_funct           (rsp_out_funct),
    .rsp_out_timeout         (rsp_out_timeout),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .busy                    (busy),
    .timeout_cnt             (timeout_cnt)
  );

  always #5 clk = ~clk;

  // Cfu model: cmd_ready tied to rsp_ready, product answered same cycle
  always_comb begin
    cmd_ready = rsp_ready;
    rsp_valid = stray || (mode_imm && cmd_valid && cmd_ready &&
                          (cmd_payload_function_id[2:0] != 3'd0));
    rsp_payload_outputs_0 = stray ? 32'hDEAD_BEEF :
                            cmd_payload_inputs_0 * cmd_payload_inputs_1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (cmd_valid && cmd_ready) begin
        hs_cnt++;
        run++;
      end else if (run != 0) begin
        last_run = run;
        run = 0;
      end
      if (rsp_out_valid && rsp_out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_rsp: got %h/%h/%b, required none",
                   rsp_out_data, rsp_out_funct, rsp_out_timeout);
        end else begin
          mon_e = exp_q.pop_front();
          if ({rsp_out_data, rsp_out_funct, rsp_out_timeout} !== mon_e) begin
            n_fail++;
            $display("FAIL rsp_order: got %h/%h/%b, required %h/%h/%b",
                     rsp_out_data, rsp_out_funct, rsp_out_timeout,
                     mon_e.d, mon_e.f, mon_e.t);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  // called #1 after a rising edge; returns #1 after the accepting edge
  task automatic push(input logic [9:0] f, input logic [31:0] a,
                      input logic [31:0] b, input logic exp_en,
                      input logic [31:0] ed, input logic eto);
    int n = 0;
    cmd_in_valid = 1'b1;
    cmd_in_funct = f;
    cmd_in_op0   = a;
    cmd_in_op1   = b;
    while (!cmd_in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("push_stuck", {63'd0, cmd_in_ready}, 64'd1);
    if (exp_en) exp_q.push_back({ed, f, eto});
    @(posedge clk);
    #1;
    cmd_in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string nm);
    int n = 0;
    while ((busy || rsp_out_valid) && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(nm, {63'd0, busy || rsp_out_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_cmd_valid", {63'd0, cmd_valid}, 0);
    chk("rst_rsp_ready", {63'd0, rsp_ready}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_tcnt", {56'd0, timeout_cnt}, 0);
    chk("rst_rsp_out_valid", {63'd0, rsp_out_valid}, 0);
    chk("rst_payload", {22'd0, cmd_payload_function_id,
                        cmd_payload_inputs_0}, 0);
    chk("rst_in_ready", {63'd0, cmd_in_ready}, 1);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // single command, same-cycle answer, 2-cycle issue latency
    push(10'd3, 32'd5, 32'd7, 1'b1, 32'h23, 1'b0);
    chk("lat_early", {63'd0, cmd_valid}, 0);
    @(posedge clk);
    #1;
    chk("lat_valid", {63'd0, cmd_valid}, 1);
    chk("lat_funct", {54'd0, cmd_payload_function_id}, 3);
    chk("lat_op0", {32'd0, cmd_payload_inputs_0}, 5);
    chk("lat_op1", {32'd0, cmd_payload_inputs_1}, 7);
    wait_idle(50, "t1_idle");
    chk("t1_busy", {63'd0, busy}, 0);

    // back-to-back: one handshake per cycle
    last_run = 0;
    base = hs_cnt;
    push(10'd7, 32'd1, 32'd1, 1'b1, 32'd1, 1'b0);
    push(10'd7, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0);
    push(10'd7, 32'd4, 32'd5, 1'b1, 32'd20, 1'b0);
    push(10'd7, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0);
    wait_idle(50, "b2b_idle");
    chk("b2b_hs", 64'(hs_cnt - base), 4);
    chk("b2b_run", 64'(last_run), 4);

    // NOP issued, only funct 3 answers
    base = hs_cnt;
    push(10'h008, 32'd1, 32'd1, 1'b0, 32'd0, 1'b0);
    push(10'd3, 32'd2, 32'd3, 1'b1, 32'd6, 1'b0);
    wait_idle(400, "nop_idle");
    chk("nop_hs", 64'(hs_cnt - base), 2);
    chk("nop_sb_empty", 64'(exp_q.size()), 0);

    // timeout after 255 waiting cycles
    mode_imm = 1'b0;
    push(10'd5, 32'hAA, 32'hBB, 1'b1, 32'd0, 1'b1);
    repeat (200) @(posedge clk);
    #1;
    chk("to_early", {63'd0, rsp_out_valid}, 0);
    chk("to_busy", {63'd0, busy}, 1);
    chk("to_cnt0", {56'd0, timeout_cnt}, 0);
    wait_idle(200, "to_idle");
    chk("to_cnt1", {56'd0, timeout_cnt}, 1);
    stray = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    stray = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("stray_rsp", {63'd0, rsp_out_valid}, 0);
    chk("stray_busy", {63'd0, busy}, 0);
    chk("stray_sb_empty", 64'(exp_q.size()), 0);

    // response FIFO full stalls issue
    mode_imm = 1'b1;
    rsp_out_ready = 1'b0;
    base = hs_cnt;
    for (int i = 1; i <= 6; i++)
      push(10'(i), 32'(i), 32'd16, 1'b1, full_exp[i-1], 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("full_out_valid", {63'd0, rsp_out_valid}, 1);
    chk("full_cmd_valid", {63'd0, cmd_valid}, 0);
    chk("full_rsp_ready", {63'd0, rsp_ready}, 0);
    chk("full_busy", {63'd0, busy}, 1);
    chk("full_hs", 64'(hs_cnt - base), 4);
    chk("full_head", {32'd0, rsp_out_data}, 32'h10);
    rsp_out_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_out_ready = 1'b0;
    chk("full_resume", {63'd0, cmd_valid}, 1);
    @(posedge clk);
    #1;
    chk("full_hs5", 64'(hs_cnt - base), 5);
    rsp_out_ready = 1'b1;
    wait_idle(100, "full_idle");
    chk("full_hs6", 64'(hs_cnt - base), 6);
    chk("full_sb_empty", 64'(exp_q.size()), 0);

    // reset during WAIT_RSP with queued commands
    mode_imm = 1'b0;
    push(10'd9, 32'd1, 32'd2, 1'b0, 32'd0, 1'b0);
    push(10'd10, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0);
    push(10'd11, 32'd5, 32'd6, 1'b0, 32'd0, 1'b0);
    push(10'd12, 32'd7, 32'd8, 1'b0, 32'd0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("wait_busy", {63'd0, busy}, 1);
    chk("wait_cmd_valid", {63'd0, cmd_valid}, 0);
    chk("wait_rsp_ready", {63'd0, rsp_ready}, 1);
    chk("wait_tcnt", {56'd0, timeout_cnt}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cmd_valid", {63'd0, cmd_valid}, 0);
    chk("arst_rsp_ready", {63'd0, rsp_ready}, 0);
    chk("arst_busy", {63'd0, busy}, 0);
    chk("arst_tcnt", {56'd0, timeout_cnt}, 0);
    chk("arst_out_valid", {63'd0, rsp_out_valid}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mode_imm = 1'b1;
    base = hs_cnt;
    repeat (20) @(posedge clk);
    #1;
    chk("post_busy", {63'd0, busy}, 0);
    chk("post_out_valid", {63'd0, rsp_out_valid}, 0);
    chk("post_hs", 64'(hs_cnt - base), 0);
    chk("post_in_ready", {63'd0, cmd_in_ready}, 1);
    chk("final_sb_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
